// File: rtl/wm8731_adc_rx_if.sv
// wm8731_adc_rx_if: parallel sample handshake between the WM8731 ADC
// receiver and the game audio logic.
//   sample_ready  consumer -> receiver  accept current pair
//   left_sample   receiver -> consumer  last complete left word
//   right_sample  receiver -> consumer  last complete right word
//   sample_valid  receiver -> consumer  pair available, held until accepted
//   overrun       receiver -> consumer  1-clk pulse, unaccepted pair overwritten
//   frame_err     receiver -> consumer  1-clk pulse, LRCK edge before word complete
`timescale 1ns/1ps
interface wm8731_adc_rx_if #(
    parameter int WIDTH = 16
);
    logic             sample_ready;
    logic [WIDTH-1:0] left_sample;
    logic [WIDTH-1:0] right_sample;
    logic             sample_valid;
    logic             overrun;
    logic             frame_err;

    modport master (
        input  sample_ready,
        output left_sample, right_sample, sample_valid, overrun, frame_err
    );

    modport slave (
        output sample_ready,
        input  left_sample, right_sample, sample_valid, overrun, frame_err
    );
endinterface

// File: rtl/wm8731_adc_rx.sv
// wm8731_adc_rx: I2S capture from a WM8731 ADC (codec is bus master).
// All codec pins are oversampled in the clk domain; nothing runs on BCLK.
// Ports:
//   clk, reset_n      system clock (>= 8x BCLK), async active-low reset
//   AUD_BCLK          codec bit clock (async)
//   AUD_ADCLRCK       codec frame clock, 0 = left, 1 = right
//   AUD_ADCDAT        codec serial data, MSB first after a one-bit delay
//   smp               sample handshake (master side)
`timescale 1ns/1ps
module wm8731_adc_rx #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            AUD_BCLK,
    input  logic            AUD_ADCLRCK,
    input  logic            AUD_ADCDAT,
    wm8731_adc_rx_if.master smp
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    state_t           state, state_d;
    logic [1:0][2:0]  pin_sync;     // [stage][{bclk, lrck, dat}]
    logic             bclk_prev;
    logic             lrck_q;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift, left_hold, left_r, right_r;
    logic             left_ok, left_ok_d;
    logic             valid_r, overrun_r, ferr_r;
    logic             store_left, publish, ferr_d;

    // All three pins share one synchronizer depth so DAT/LRCK line up
    // exactly with the detected BCLK rise.
    wire bclk_s    = pin_sync[1][2];
    wire lrck_s    = pin_sync[1][1];
    wire dat_s     = pin_sync[1][0];
    wire bclk_rise = bclk_s & ~bclk_prev;
    wire lrck_edge = bclk_rise & (lrck_s != lrck_q);
    // The rise that reveals an LRCK edge is the I2S delay slot: no capture.
    wire cap       = bclk_rise & ~lrck_edge & (state != SYNC) & (bit_cnt < CNT_FULL);
    wire [WIDTH-1:0] shift_nxt = {shift[WIDTH-2:0], dat_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pin_sync  <= '0;
            bclk_prev <= 1'b0;
        end else begin
            pin_sync  <= {pin_sync[0], {AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT}};
            bclk_prev <= bclk_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SYNC;
        else          state <= state_d;
    end

    always_comb begin
        state_d    = state;
        left_ok_d  = left_ok;
        store_left = 1'b0;
        publish    = 1'b0;
        ferr_d     = 1'b0;
        case (state)
            SYNC: begin
                // Only a falling LRCK edge starts a frame we can trust.
                if (lrck_edge && !lrck_s) state_d = LEFT;
            end
            LEFT: begin
                if (lrck_edge && lrck_s) begin
                    state_d = RIGHT;
                    if (bit_cnt == CNT_FULL) begin
                        store_left = 1'b1;
                        left_ok_d  = 1'b1;
                    end else begin
                        ferr_d    = 1'b1;
                        left_ok_d = 1'b0;
                    end
                end
            end
            RIGHT: begin
                // bit_cnt stops at WIDTH, so this fires once per frame.
                if (cap && bit_cnt == CNT_LAST && left_ok) publish = 1'b1;
                if (lrck_edge && !lrck_s) begin
                    if (bit_cnt < CNT_FULL) ferr_d = 1'b1;
                    left_ok_d = 1'b0;
                    state_d   = LEFT;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lrck_q    <= 1'b0;
            bit_cnt   <= '0;
            shift     <= '0;
            left_hold <= '0;
            left_ok   <= 1'b0;
            left_r    <= '0;
            right_r   <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            if (bclk_rise) lrck_q <= lrck_s;
            if (lrck_edge)  bit_cnt <= '0;
            else if (cap)   bit_cnt <= bit_cnt + 1'b1;
            if (cap)        shift <= shift_nxt;
            if (store_left) left_hold <= shift;
            left_ok   <= left_ok_d;
            ferr_r    <= ferr_d;
            overrun_r <= 1'b0;
            if (publish) begin
                left_r    <= left_hold;
                right_r   <= shift_nxt;
                valid_r   <= 1'b1;
                // Publishing on the accept cycle is a clean hand-over.
                overrun_r <= valid_r & ~smp.sample_ready;
            end else if (valid_r && smp.sample_ready) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign smp.left_sample  = left_r;
    assign smp.right_sample = right_r;
    assign smp.sample_valid = valid_r;
    assign smp.overrun      = overrun_r;
    assign smp.frame_err    = ferr_r;
endmodule

// File: tb/tb_wm8731_adc_rx.sv
`timescale 1ns/1ps
module tb_wm8731_adc_rx;
    localparam int W = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic bclk    = 1'b0;
    logic lrck    = 1'b0;
    logic dat     = 1'b0;

    wm8731_adc_rx_if #(.WIDTH(W)) sif();

    wm8731_adc_rx #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .AUD_BCLK    (bclk),
        .AUD_ADCLRCK (lrck),
        .AUD_ADCDAT  (dat),
        .smp         (sif)
    );

    initial forever #10 clk = ~clk;

    typedef struct {
        logic [W-1:0] lw;
        logic [W-1:0] rw;
        int           lslot;   // BCLK periods in the left slot
        bit           pub;     // pair expected on the handshake
        int           mode;    // 0 none, 1 latency check, 2 accept on publish cycle
    } frame_t;

    int checks   = 0;
    int failures = 0;
    int ovr_cnt  = 0;
    int ferr_cnt = 0;
    logic [2*W-1:0] sb[$];
    logic [2*W-1:0] mon_exp;
    logic [W-1:0]   cur_l, cur_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: a pair is consumed at the clk edge after valid&ready.
    always begin
        @(negedge clk);
        #5;
        if (sif.overrun === 1'b1)   ovr_cnt++;
        if (sif.frame_err === 1'b1) ferr_cnt++;
        if (reset_n && sif.sample_valid && sif.sample_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pair: got 0x%0h/0x%0h expected none",
                         sif.left_sample, sif.right_sample);
            end else begin
                mon_exp = sb.pop_front();
                chk("pair_left",  {16'h0, sif.left_sample},  {16'h0, mon_exp[2*W-1:W]});
                chk("pair_right", {16'h0, sif.right_sample}, {16'h0, mon_exp[W-1:0]});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    // One BCLK period = 16 clk: LRCK/DAT change with the falling edge.
    task automatic bclk_bit(input logic lr, input logic d, input int mode);
        @(negedge clk);
        bclk = 1'b0; lrck = lr; dat = d;
        repeat (8) @(negedge clk);
        bclk = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (mode == 1) begin
                if (i < 3)  chk("lat_before_e2", {31'h0, sif.sample_valid}, 32'h0);
                if (i == 3) chk("lat_at_e2",     {31'h0, sif.sample_valid}, 32'h1);
            end
            if (mode == 2) begin
                if (i == 2) sif.sample_ready = 1'b1;
                if (i == 3) begin
                    sif.sample_ready = 1'b0;
                    chk("acc_pub_valid",   {31'h0, sif.sample_valid}, 32'h1);
                    chk("acc_pub_overrun", {31'h0, sif.overrun},      32'h0);
                    chk("acc_pub_left",    {16'h0, sif.left_sample},  {16'h0, cur_l});
                    chk("acc_pub_right",   {16'h0, sif.right_sample}, {16'h0, cur_r});
                end
            end
        end
    endtask

    // Bits past the word are driven as 1 so stray captures would show up.
    task automatic send_slot(input logic lr, input logic [W-1:0] w, input int nslot, input int mode);
        logic d;
        for (int b = 0; b < nslot; b++) begin
            if (b == 0)      d = 1'b0;
            else if (b <= W) d = w[W-b];
            else             d = 1'b1;
            bclk_bit(lr, d, (b == W) ? mode : 0);
        end
    endtask

    task automatic run_frame(input frame_t f);
        cur_l = f.lw;
        cur_r = f.rw;
        if (f.pub) sb.push_back({f.lw, f.rw});
        send_slot(1'b0, f.lw, f.lslot, 0);
        send_slot(1'b1, f.rw, 32, f.mode);
    endtask

    task automatic do_reset(input logic rdy);
        sif.sample_ready = rdy;
        reset_n = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic lead_in();
        send_slot(1'b1, 16'hC5A3, 32, 0);
    endtask

    task automatic drain();
        sif.sample_ready = 1'b1;
        repeat (4) @(negedge clk);
        sif.sample_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        frame_t t1[3];
        frame_t t3[2];
        frame_t f;
        int o0, e0;

        t1[0] = '{16'h1234, 16'hABCD, 32, 1'b1, 1};
        t1[1] = '{16'h8001, 16'h0001, 32, 1'b1, 1};
        t1[2] = '{16'h7FFF, 16'hFFFF, 32, 1'b1, 1};
        t3[0] = '{16'h5A5A, 16'hC3C3, 11, 1'b0, 0};
        t3[1] = '{16'h0F0F, 16'h8888, 32, 1'b1, 1};

        // reset values
        sif.sample_ready = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid",   {31'h0, sif.sample_valid}, 32'h0);
        chk("rst_left",    {16'h0, sif.left_sample},  32'h0);
        chk("rst_right",   {16'h0, sif.right_sample}, 32'h0);
        chk("rst_overrun", {31'h0, sif.overrun},      32'h0);
        chk("rst_ferr",    {31'h0, sif.frame_err},    32'h0);

        // three frames, ready tied high
        do_reset(1'b1);
        lead_in();
        o0 = ovr_cnt; e0 = ferr_cnt;
        foreach (t1[i]) run_frame(t1[i]);
        repeat (20) @(negedge clk);
        chk("t1_all_published", sb.size(), 32'h0);
        chk("t1_overruns", ovr_cnt - o0, 32'h0);
        chk("t1_frame_errs", ferr_cnt - e0, 32'h0);

        // same frames, consumer stalled
        do_reset(1'b0);
        lead_in();
        o0 = ovr_cnt; e0 = ferr_cnt;
        foreach (t1[i]) begin
            f = t1[i];
            f.mode = 0;
            run_frame(f);
        end
        repeat (5) @(negedge clk);
        chk("t2_valid_held", {31'h0, sif.sample_valid}, 32'h1);
        chk("t2_left_last",  {16'h0, sif.left_sample},  32'h7FFF);
        chk("t2_right_last", {16'h0, sif.right_sample}, 32'hFFFF);
        chk("t2_overruns", ovr_cnt - o0, 32'h2);
        chk("t2_frame_errs", ferr_cnt - e0, 32'h0);
        void'(sb.pop_front());
        void'(sb.pop_front());
        drain();
        chk("t2_drained", sb.size(), 32'h0);

        // short left word
        do_reset(1'b1);
        lead_in();
        o0 = ovr_cnt; e0 = ferr_cnt;
        foreach (t3[i]) run_frame(t3[i]);
        repeat (20) @(negedge clk);
        chk("t3_frame_errs", ferr_cnt - e0, 32'h1);
        chk("t3_next_published", sb.size(), 32'h0);
        chk("t3_overruns", ovr_cnt - o0, 32'h0);

        // reset released mid-right-word
        sif.sample_ready = 1'b1;
        reset_n = 1'b0;
        sb.delete();
        e0 = ferr_cnt;
        for (int b = 0; b < 32; b++) begin
            if (b == 8) reset_n = 1'b1;
            bclk_bit(1'b1, 1'($urandom_range(1)), 0);
        end
        chk("t4_idle_before_frame", {31'h0, sif.sample_valid}, 32'h0);
        f = '{16'h2468, 16'h1357, 32, 1'b1, 1};
        run_frame(f);
        repeat (20) @(negedge clk);
        chk("t4_published", sb.size(), 32'h0);
        chk("t4_frame_errs", ferr_cnt - e0, 32'h0);

        // async reset mid-left-word with a pair pending
        do_reset(1'b0);
        lead_in();
        f = '{16'hDEAD, 16'hBEEF, 32, 1'b1, 0};
        run_frame(f);
        for (int b = 0; b < 6; b++) bclk_bit(1'b0, 1'b1, 0);
        chk("t5_valid_pending", {31'h0, sif.sample_valid}, 32'h1);
        #3 reset_n = 1'b0;
        #1;
        chk("t5_async_valid", {31'h0, sif.sample_valid}, 32'h0);
        chk("t5_async_left",  {16'h0, sif.left_sample},  32'h0);
        chk("t5_async_right", {16'h0, sif.right_sample}, 32'h0);
        chk("t5_async_ovr",   {31'h0, sif.overrun},      32'h0);
        chk("t5_async_ferr",  {31'h0, sif.frame_err},    32'h0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;

        // accept on the same cycle as the next publish
        do_reset(1'b0);
        lead_in();
        o0 = ovr_cnt;
        f = '{16'h1111, 16'h2222, 32, 1'b1, 0};
        run_frame(f);
        f = '{16'h3C3C, 16'hE001, 32, 1'b1, 2};
        run_frame(f);
        drain();
        chk("t6_drained", sb.size(), 32'h0);
        chk("t6_overruns", ovr_cnt - o0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wm8731_adc_rx.md
# wm8731_adc_rx

Receives the WM8731 ADC serial stream (I2S, codec in master mode) and presents parallel left/right sample pairs to the game audio logic. It is the capture counterpart to the DAC output path, sharing the same AUD_BCLK and the same codec. All codec pins are oversampled in the system clock domain; no logic runs on AUD_BCLK.

## Interface
- WIDTH, 16, bits captured per channel, MSB first; allowed range 8–24.
- clk  in  1  system clock (50 MHz); must be at least 8× the AUD_BCLK frequency.
- reset_n  in  1  asynchronous, active-low reset.
- AUD_BCLK  in  1  codec bit clock, asynchronous to clk.
- AUD_ADCLRCK  in  1  codec ADC frame clock; 0 = left, 1 = right.
- AUD_ADCDAT  in  1  codec ADC serial data.
- sample_ready  in  1  consumer accepts the current pair.
- left_sample  out  WIDTH  last complete left word (two's complement).
- right_sample  out  WIDTH  last complete right word.
- sample_valid  out  1  pair available; held until accepted.
- overrun  out  1  one-clk pulse: an unaccepted pair was overwritten.
- frame_err  out  1  one-clk pulse: an LRCK edge arrived before WIDTH bits were captured.

## Operation
- Synchronizers: AUD_BCLK, AUD_ADCLRCK, and AUD_ADCDAT each pass through an identical 2-FF synchronizer.
- Edge detect: a third register on the synchronized BCLK produces a bclk_rise strobe (sync & ~prev).
- Per-bclk_rise rule: all capture and state actions happen only in clk cycles where bclk_rise is 1. Synchronized LRCK and DAT are used in that same cycle.
- lrck_q holds the LRCK value seen at the previous bclk_rise. An LRCK edge is a bclk_rise where synchronized LRCK ≠ lrck_q.
- Delay slot: on an LRCK edge, bit_cnt clears to 0 and no bit is captured. This is the I2S one-bit delay.
- Capture: on each later bclk_rise, while bit_cnt < WIDTH, shift DAT into the channel shift register (MSB first) and increment bit_cnt. Bits beyond WIDTH are ignored.
- States:
  - SYNC (reset state): ignore data. Go to LEFT on an LRCK edge with new LRCK = 0.
  - LEFT: capture the left word. On an LRCK edge with new LRCK = 1:
    - if bit_cnt = WIDTH, store the word in left_hold, set left_ok = 1, go to RIGHT;
    - otherwise pulse frame_err, clear left_ok, go to RIGHT.
  - RIGHT: capture the right word. When bit_cnt reaches WIDTH and left_ok = 1, publish the pair:
    - left_sample ← left_hold, right_sample ← shift register, sample_valid ← 1;
    - publication happens once per frame, at the capture of the right LSB.
    - On an LRCK edge with new LRCK = 0: if bit_cnt < WIDTH, pulse frame_err. Clear left_ok, go to LEFT.
- Handshake:
  - sample_valid & sample_ready at a clk edge → sample_valid = 0 next cycle.
  - Publish while sample_valid = 1 and sample_ready = 0 → outputs overwritten, sample_valid stays 1, overrun pulses.
  - Publish in the same cycle as an accept → new data loaded, sample_valid stays 1, no overrun.
- Reset (asynchronous, any time, including mid-frame): state = SYNC, bit_cnt = 0, left_ok = 0, shift/hold registers = 0.
  - Output reset values: left_sample = 0, right_sample = 0, sample_valid = 0, overrun = 0, frame_err = 0.
  - After release, the first published pair comes from the first complete left/right frame that starts at an LRCK falling edge.

## Timing
- Latency: a pin-level AUD_BCLK rise is first sampled at clk edge E0. bclk_rise is high in the cycle after E1. All register updates driven by that rise, including sample_valid and overrun, occur at E2.
- AUD_BCLK high and low phases must each last ≥ 3 clk periods. Shorter phases are unsupported and need not be detected.
- DAT and LRCK share the BCLK synchronizer depth, so bit alignment to bclk_rise is exact.
- overrun and frame_err are single-cycle and never both caused by the same bclk_rise.
- sample_ready is ignored when sample_valid = 0.

## Test plan
- Reset, then 3 I2S frames (BCLK = clk/16, 32-bit slots), left words 0x1234/0x8001/0x7FFF and right words 0xABCD/0x0001/0xFFFF, with sample_ready tied 1:
  - expect 3 sample_valid pulses carrying the exact pairs;
  - each pulse is 2 clk edges after the synchronized right-LSB BCLK rise.
- Same frames with sample_ready = 0: expect sample_valid stuck at 1, overrun pulsing at frames 2 and 3, and outputs = 0x7FFF/0xFFFF at the end.
- Left channel cut to 10 bits: expect one frame_err pulse, no publication for that frame, and the next full frame published normally.
- Reset released mid-right-word with LRCK = 1: expect no output until after the next LRCK 1→0 edge and one complete frame.
- Assert reset_n low mid-left-word while sample_valid = 1: expect all outputs 0 immediately, without waiting for a clk edge.
- Drive sample_ready high in the same cycle as a publish: expect new data, sample_valid held at 1, overrun = 0.
